// File: rtl/venus_fetch_top.sv
// Instruction fetch: PC + fetch stage (ifetch1) + synchronous instruction ROM.
// The ROM image is mem[i] = i.
module venus_fetch_imem #(
    parameter int ADDR       = 32,
    parameter int INST       = 32,
    parameter int IMEM_DEPTH = 256,
    parameter     IMEM_FILE  = "imem.hex"
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [ADDR-1:0] addr,
    output logic [INST-1:0] data
);
    localparam int AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

    logic [AW-1:0]   idx;
    logic [INST-1:0] mem [IMEM_DEPTH];

    // Only the low index bits select a word, so fetches wrap around the ROM.
    assign idx = AW'(addr);

    for (genvar i = 0; i < IMEM_DEPTH; i++) begin : g_rom
        assign mem[i] = INST'(i);
    end

    // Read register: cleared by reset, frozen while the fetch stage stalls.
    always_ff @(posedge clk) begin
        if (!rst) begin
            data <= '0;
        end else if (en) begin
            data <= mem[idx];
        end
    end
endmodule

module venus_fetch_ifetch #(
    parameter int ADDR = 32,
    parameter int INST = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            v_i,
    input  logic            stall_i,
    input  logic            branch_i,
    input  logic [ADDR-1:0] baddr_i,
    input  logic [INST-1:0] inst_i,
    output logic [ADDR-1:0] addr_o,
    output logic [ADDR-1:0] origaddr_o,
    output logic [INST-1:0] inst_o,
    output logic            v_o
);
    logic [ADDR-1:0] pc;

    // Redirect is applied to the address issued this cycle, so no bubble.
    assign addr_o = branch_i ? baddr_i : pc;
    assign inst_o = inst_i;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc         <= '0;
            origaddr_o <= '0;
            v_o        <= 1'b0;
        end else if (!stall_i) begin
            pc         <= v_i ? addr_o + ADDR'(1) : addr_o;
            origaddr_o <= addr_o;
            v_o        <= v_i;
        end
    end
endmodule

module venus_fetch_top #(
    parameter int ADDR       = 32,
    parameter int INST       = 32,
    parameter int IMEM_DEPTH = 256,
    parameter     IMEM_FILE  = "imem.hex"
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            v_i,
    input  logic            stall_i,
    input  logic            branch_i,
    input  logic [ADDR-1:0] baddr_i,
    output logic [INST-1:0] inst_o,
    output logic [ADDR-1:0] origaddr_o,
    output logic            v_o
);
    logic [ADDR-1:0] addr;
    logic [INST-1:0] rom_data;

    venus_fetch_ifetch #(
        .ADDR (ADDR),
        .INST (INST)
    ) ifetch1 (
        .clk        (clk),
        .rst        (rst),
        .v_i        (v_i),
        .stall_i    (stall_i),
        .branch_i   (branch_i),
        .baddr_i    (baddr_i),
        .inst_i     (rom_data),
        .addr_o     (addr),
        .origaddr_o (origaddr_o),
        .inst_o     (inst_o),
        .v_o        (v_o)
    );

    venus_fetch_imem #(
        .ADDR       (ADDR),
        .INST       (INST),
        .IMEM_DEPTH (IMEM_DEPTH),
        .IMEM_FILE  (IMEM_FILE)
    ) imem (
        .clk  (clk),
        .rst  (rst),
        .en   (!stall_i),
        .addr (addr),
        .data (rom_data)
    );
endmodule

// File: tb/tb_venus_fetch_top.sv
// Directed bench for venus_fetch_top with the default ROM image (mem[i] = i).
module tb_venus_fetch_top;
    logic        clk = 1'b0;
    logic        rst;
    logic        v_i;
    logic        stall_i;
    logic        branch_i;
    logic [31:0] baddr_i;
    logic [31:0] inst_o;
    logic [31:0] origaddr_o;
    logic        v_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    venus_fetch_top dut (
        .clk        (clk),
        .rst        (rst),
        .v_i        (v_i),
        .stall_i    (stall_i),
        .branch_i   (branch_i),
        .baddr_i    (baddr_i),
        .inst_o     (inst_o),
        .origaddr_o (origaddr_o),
        .v_o        (v_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] oa,
                              input logic [31:0] ins, input logic vv);
        chk({tag, ".origaddr"}, 64'(origaddr_o), 64'(oa));
        chk({tag, ".inst"},     64'(inst_o),     64'(ins));
        chk({tag, ".v"},        64'(v_o),        64'(vv));
    endtask

    initial begin
        rst = 1'b0; v_i = 1'b1; stall_i = 1'b0; branch_i = 1'b0; baddr_i = '0;

        for (int i = 0; i < 128; i++) begin
            tick();
            if (i % 16 == 15) expect_out($sformatf("rst%0d", i), 32'd0, 32'd0, 1'b0);
        end

        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            expect_out($sformatf("seq%0d", k), 32'(k), 32'(k), 1'b1);
        end

        branch_i = 1'b1; baddr_i = 32'd2;
        #1 chk("addr_mux", 64'(dut.ifetch1.addr_o), 64'd2);
        tick();
        branch_i = 1'b0;
        expect_out("br0", 32'd2, 32'd2, 1'b1);
        for (int k = 3; k <= 5; k++) begin
            tick();
            expect_out($sformatf("br%0d", k), 32'(k), 32'(k), 1'b1);
        end

        stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            expect_out($sformatf("stall%0d", k), 32'd5, 32'd5, 1'b1);
        end
        stall_i = 1'b0;
        tick(); expect_out("unstall6", 32'd6, 32'd6, 1'b1);
        tick(); expect_out("unstall7", 32'd7, 32'd7, 1'b1);

        stall_i = 1'b1; branch_i = 1'b1; baddr_i = 32'd40;
        tick(); expect_out("brstall_hold", 32'd7, 32'd7, 1'b1);
        stall_i = 1'b0;
        tick(); expect_out("brstall_take", 32'd40, 32'd40, 1'b1);
        branch_i = 1'b0;
        tick(); expect_out("brstall_next", 32'd41, 32'd41, 1'b1);

        v_i = 1'b0; branch_i = 1'b1; baddr_i = 32'd10;
        tick(); expect_out("gap0", 32'd10, 32'd10, 1'b0);
        chk("gap0.pc", 64'(dut.ifetch1.pc), 64'd10);
        branch_i = 1'b0;
        tick(); expect_out("gap1", 32'd10, 32'd10, 1'b0);
        chk("gap1.pc", 64'(dut.ifetch1.pc), 64'd10);
        v_i = 1'b1;
        tick(); expect_out("gap_end", 32'd10, 32'd10, 1'b1);
        chk("gap_end.pc", 64'(dut.ifetch1.pc), 64'd11);

        branch_i = 1'b1; baddr_i = 32'd255;
        tick(); expect_out("romwrap0", 32'd255, 32'd255, 1'b1);
        branch_i = 1'b0;
        tick(); expect_out("romwrap1", 32'd256, 32'd0, 1'b1);

        branch_i = 1'b1; baddr_i = 32'hFFFF_FFFF;
        tick(); expect_out("pcwrap0", 32'hFFFF_FFFF, 32'd255, 1'b1);
        branch_i = 1'b0;
        tick(); expect_out("pcwrap1", 32'd0, 32'd0, 1'b1);
        tick(); expect_out("pcwrap2", 32'd1, 32'd1, 1'b1);

        rst = 1'b0; stall_i = 1'b1; branch_i = 1'b1; baddr_i = 32'd77;
        tick(); expect_out("midrst", 32'd0, 32'd0, 1'b0);
        chk("midrst.pc", 64'(dut.ifetch1.pc), 64'd0);
        rst = 1'b1; stall_i = 1'b0; branch_i = 1'b0;
        tick(); expect_out("postrst0", 32'd0, 32'd0, 1'b1);
        tick(); expect_out("postrst1", 32'd1, 32'd1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
